// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and its consumers.
// The optional response bypass is enabled by defining IFU_BYPASS_EN.
package ifu_pkg;

  localparam int IFU_PC_WIDTH   = 64;
  localparam int IFU_INST_WIDTH = 32;

  localparam logic [IFU_PC_WIDTH-1:0]   IFU_PC_STEP = 64'd4;
  // addi x0, x0, 0 -- what IF/ID loads when it is flushed
  localparam logic [IFU_INST_WIDTH-1:0] IFU_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [IFU_PC_WIDTH-1:0]   pc;
    logic [IFU_INST_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, inst} with clear, registered head
// and an occupancy count used for request credit.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          clear,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: sequential PC generation, one-outstanding imem requests,
// prefetch FIFO to decode, EX redirect flush. Optional bypass: IFU_BYPASS_EN.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int                  PC_WIDTH   = IFU_PC_WIDTH,
  parameter int                  INST_WIDTH = IFU_INST_WIDTH,
  parameter int                  FIFO_DEPTH = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 'h80000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  output ifu_state_e            dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid && ready. imem_req_valid
  // never drops before ready except on redirect/reset; out_valid is void in a
  // redirect cycle; imem responses carry no ready and are accepted unconditionally.

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  ifu_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                armed_q;

  logic                req_fire;
  logic                outstanding;
  logic                credit_ok;
  logic                bypass_hit;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  fetch_entry_t        fifo_head;
  fetch_entry_t        push_entry;

  // Buffered entries plus the in-flight one may never exceed the FIFO size,
  // which is what makes a push into a full FIFO impossible.
  assign outstanding = (state_q != RUN);
  assign credit_ok   = (32'(fifo_count) + 32'(outstanding)) < 32'(FIFO_DEPTH);

  assign imem_req_valid = armed_q && (state_q == RUN) && credit_ok && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

`ifdef IFU_BYPASS_EN
  assign bypass_hit = fifo_empty && imem_resp_valid && (state_q == WAIT) && !redirect_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  assign out_valid = !redirect_valid && (!fifo_empty || bypass_hit);
  assign out_pc    = bypass_hit ? req_pc_q       : fifo_head.pc;
  assign out_inst  = bypass_hit ? imem_resp_inst : fifo_head.inst;
  assign fifo_pop  = !fifo_empty && out_ready && !redirect_valid;

  assign push_entry = '{pc: req_pc_q, inst: imem_resp_inst};
  assign dbg_state  = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    fifo_push  = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~PC_WIDTH'(3);
      // A response landing in the redirect cycle retires the outstanding request.
      state_d = (state_q != RUN && !imem_resp_valid) ? DRAIN : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_WIDTH'(IFU_PC_STEP);
            req_pc_d   = fetch_pc_q;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            fifo_push = !(bypass_hit && out_ready);
            state_d   = RUN;
          end
        end
        DRAIN: begin
          if (imem_resp_valid) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      armed_q    <= 1'b1;
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .clear     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a latency-programmable instruction memory model.
`timescale 1ns/1ps
module tb_ifu_prefetch;
  import ifu_pkg::*;

  localparam int PW = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [PW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [IW-1:0] imem_resp_inst;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_pc;
  logic [IW-1:0] out_inst;
  ifu_state_e    dbg_state;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;

  logic [PW-1:0] obs_pc_q[$];
  logic [IW-1:0] obs_inst_q[$];
  logic [PW-1:0] acc_q[$];
  logic [PW-1:0] exp_q[$];

  ifu_prefetch dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] inst_of(input logic [PW-1:0] a);
    return ~a[31:0] ^ 32'h0000_0013;
  endfunction

  // ---------------- memory model: one response mem_lat cycles after acceptance
  initial begin : mem_model
    bit            busy;
    int            cnt;
    logic [PW-1:0] addr;
    busy = 1'b0;
    cnt = 0;
    addr = '0;
    imem_resp_valid = 1'b0;
    imem_resp_inst = '0;
    forever begin
      @(negedge clk);
      if (!rst) busy = 1'b0;
      else if (imem_req_valid && imem_req_ready) begin
        busy = 1'b1;
        cnt = mem_lat;
        addr = imem_req_addr;
      end
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (busy && rst) begin
        cnt--;
        if (cnt <= 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_inst = inst_of(addr);
          busy = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      obs_pc_q.push_back(out_pc);
      obs_inst_q.push_back(out_inst);
    end
    if (rst && imem_req_valid && imem_req_ready) acc_q.push_back(imem_req_addr);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    obs_pc_q.delete();
    obs_inst_q.delete();
    acc_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_pc_q.size() < n; i++) cyc();
  endtask

  // Quiesce, then redirect to a known base with the memory idle and the FIFO empty.
  task automatic idle(input logic [PW-1:0] base);
    cyc();
    imem_req_ready = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    repeat (6) cyc();
    redirect_valid = 1'b1;
    redirect_pc = base;
    cyc();
    redirect_valid = 1'b0;
    mem_lat = 1;
    clear_logs();
  endtask

  // Compare the first n delivered entries against exp_q.
  task automatic cmp_obs(input string name, input int n);
    checks++;
    if (obs_pc_q.size() < n) begin
      errors++;
      $display("FAIL %s_count got %0d need %0d", name, obs_pc_q.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= obs_pc_q.size() || obs_pc_q[i] !== exp_q[i] || obs_inst_q[i] !== inst_of(exp_q[i])) begin
        errors++;
        $display("FAIL %s_out[%0d] got pc %h need pc %h inst %h", name, i,
                 (i < obs_pc_q.size()) ? obs_pc_q[i] : 64'hx, exp_q[i], inst_of(exp_q[i]));
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cyc();
    cyc();
    mid();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b need 0", imem_req_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
    checks++; if (out_pc !== '0) begin errors++; $display("FAIL reset_out_pc got %h need 0", out_pc); end
    checks++; if (out_inst !== '0) begin errors++; $display("FAIL reset_out_inst got %h need 0", out_inst); end
    checks++; if (dbg_state !== RUN) begin errors++; $display("FAIL reset_state got %0d need RUN", dbg_state); end
    cyc();
    rst = 1'b1;
    mid();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL release_req_valid got %b need 0", imem_req_valid); end
    cyc();
    mid();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
      errors++; $display("FAIL first_req got v=%b a=%h need v=1 a=80000000", imem_req_valid, imem_req_addr);
    end
    clear_logs();
  endtask

  task automatic test_sequential();
    cyc();
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    mem_lat = 1;
    wait_obs(3, 40);
    for (int i = 0; i < 3; i++) exp_q.push_back(64'h8000_0000 + 64'(4 * i));
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= acc_q.size() || acc_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL seq_addr[%0d] got %h need %h", i, (i < acc_q.size()) ? acc_q[i] : 64'hx, exp_q[i]);
      end
    end
    cmp_obs("seq", 3);
  endtask

  task automatic test_backpressure();
    idle(64'h8000_1000);
    imem_req_ready = 1'b1;
    out_ready = 1'b0;
    repeat (10) cyc();
    mid();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %b need 0", imem_req_valid); end
    checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL bp_buffered got %0d need 2", acc_q.size()); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_1000) begin
      errors++; $display("FAIL bp_head got v=%b pc=%h need v=1 pc=80001000", out_valid, out_pc);
    end
    cyc();
    out_ready = 1'b1;
    wait_obs(4, 40);
    for (int i = 0; i < 4; i++) exp_q.push_back(64'h8000_1000 + 64'(4 * i));
    cmp_obs("bp_drain", 4);
  endtask

  task automatic test_redirect_wait();
    idle(64'h8000_2000);
    imem_req_ready = 1'b1;
    mem_lat = 3;
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    mid();
    checks++; if (dbg_state !== WAIT || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rw_redirect_cycle got st=%0d v=%b need WAIT v=0", dbg_state, imem_req_valid);
    end
    cyc();
    redirect_valid = 1'b0;
    mid();
    checks++; if (dbg_state !== DRAIN) begin errors++; $display("FAIL rw_drain got %0d need DRAIN", dbg_state); end
    cyc();
    mid();
    checks++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rw_discard got out_v=%b req_v=%b need 0 0", out_valid, imem_req_valid);
    end
    cyc();
    mid();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin
      errors++; $display("FAIL rw_next_req got v=%b a=%h need v=1 a=80000100", imem_req_valid, imem_req_addr);
    end
    mem_lat = 1;
    wait_obs(2, 40);
    exp_q.push_back(64'h8000_0100);
    exp_q.push_back(64'h8000_0104);
    cmp_obs("rw", 2);
  endtask

  task automatic test_redirect_resp();
    idle(64'h8000_3000);
    imem_req_ready = 1'b1;
    out_ready = 1'b0;
    mem_lat = 2;
    repeat (4) cyc();
    mid();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_pre_valid got %b need 1", out_valid); end
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0202;
    mid();
    checks++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rr_redirect_cycle got out_v=%b req_v=%b need 0 0", out_valid, imem_req_valid);
    end
    cyc();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    mid();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rr_next got v=%b a=%h ov=%b need v=1 a=80000200 ov=0", imem_req_valid, imem_req_addr, out_valid);
    end
    wait_obs(1, 40);
    exp_q.push_back(64'h8000_0200);
    cmp_obs("rr", 1);
  endtask

  task automatic test_req_stall();
    idle(64'h8000_4000);
    for (int i = 0; i < 5; i++) begin
      cyc();
      mid();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_4000) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b a=%h need v=1 a=80004000", i, imem_req_valid, imem_req_addr);
      end
    end
    cyc();
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    repeat (3) cyc();
    mid();
    checks++; if (acc_q.size() != 1 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_4004) begin
      errors++; $display("FAIL stall_advance got n=%0d v=%b a=%h need n=1 v=1 a=80004004", acc_q.size(), imem_req_valid, imem_req_addr);
    end
    cyc();
    imem_req_ready = 1'b1;
    wait_obs(2, 40);
    exp_q.push_back(64'h8000_4000);
    exp_q.push_back(64'h8000_4004);
    cmp_obs("stall", 2);
  endtask

  task automatic test_latency();
    idle(64'h8000_5000);
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    mem_lat = 2;
    cyc();
    imem_req_ready = 1'b0;
    cyc();
    mid();
`ifdef IFU_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_5000 || out_inst !== inst_of(64'h8000_5000)) begin
      errors++; $display("FAIL lat_resp_cycle got v=%b pc=%h need v=1 pc=80005000", out_valid, out_pc);
    end
    cyc();
    mid();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_after got v=%b need 0", out_valid); end
`else
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_resp_cycle got v=%b need 0", out_valid); end
    cyc();
    mid();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_5000 || out_inst !== inst_of(64'h8000_5000)) begin
      errors++; $display("FAIL lat_after got v=%b pc=%h need v=1 pc=80005000", out_valid, out_pc);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    idle(64'h8000_6000);
    imem_req_ready = 1'b1;
    out_ready = 1'b0;
    mem_lat = 1;
    cyc();
    cyc();
    mem_lat = 3;
    cyc();
    #2;
    checks++; if (dbg_state !== WAIT || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_pre got st=%0d ov=%b need WAIT 1", dbg_state, out_valid);
    end
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || out_pc !== '0 || out_inst !== '0 || dbg_state !== RUN) begin
      errors++; $display("FAIL rst_async got rv=%b ov=%b pc=%h inst=%h st=%0d need 0 0 0 0 RUN",
                         imem_req_valid, out_valid, out_pc, out_inst, dbg_state);
    end
    cyc();
    cyc();
    rst = 1'b1;
    mem_lat = 1;
    out_ready = 1'b1;
    clear_logs();
    mid();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_release got %b need 0", imem_req_valid); end
    cyc();
    mid();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
      errors++; $display("FAIL rst_refetch got v=%b a=%h need v=1 a=80000000", imem_req_valid, imem_req_addr);
    end
    wait_obs(2, 40);
    exp_q.push_back(64'h8000_0000);
    exp_q.push_back(64'h8000_0004);
    cmp_obs("rst", 2);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp();
    test_req_stall();
    test_latency();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
